sp_ram_req_ctrl: RTL

Request controller placed directly upstream of the single-port data RAM wrapper (data plus DIFT tag array). It accepts core-side requests on a req/gnt/rvalid protocol and drives the RAM's enable, address, write-data, write-enable and byte-enable pins. It returns read data and per-byte tags one cycle after grant and flags misaligned accesses. After reset it can sweep the tag array to zero before it grants any request.

---
 rtl/sp_ram_req_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sp_ram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_req_ctrl
// Description : Request controller in front of the single-port data RAM and
//               its per-byte DIFT tag array. It grants core requests on a
//               req/gnt/rvalid handshake, drives the RAM pins combinationally
//               and returns one response per grant a cycle later. Misaligned
//               accesses are granted but not forwarded, and they return
//               err_o = 1.
//               Optional macro SP_RAM_TAG_INIT_EN: after every reset, sweep
//               the tag array to zero, one word per cycle, before any grant.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_req_ctrl #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,
    // core side
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    we_tag_i,
    input  logic                    wdata_tag_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [DATA_WIDTH/8-1:0] rdata_tag_o,
    output logic                    err_o,
    output logic                    busy_o,
    // RAM side
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic                    ram_we_tag_o,
    output logic                    ram_wdata_tag_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    input  logic [DATA_WIDTH/8-1:0] ram_rdata_tag_i
);

    logic                  w_sweep_active;
    logic [ADDR_WIDTH-1:0] w_sweep_addr;
    logic                  w_aligned;

    assign w_aligned = (addr_i[1:0] == 2'b00);

`ifdef SP_RAM_TAG_INIT_EN
    localparam int C_WCNT_WIDTH = ADDR_WIDTH - 2;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [C_WCNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    // State and sweep-counter registers; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Sweep sequencing: one word per cycle, leave INIT after the all-ones word
    // so the counter never has to wrap.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        if (state_q == ST_INIT) begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (&word_cnt_q) begin
                state_d    = ST_SERVE;
                word_cnt_d = '0;
            end
        end
    end

    assign w_sweep_active = (state_q == ST_INIT);
    assign w_sweep_addr   = {word_cnt_q, 2'b00};
`else
    assign w_sweep_active = 1'b0;
    assign w_sweep_addr   = '0;
`endif

    assign busy_o = w_sweep_active;

    // Grant and RAM pin drive: sweep writes zero tags, otherwise aligned
    // requests pass straight through and everything else leaves the RAM idle.
    always_comb begin
        gnt_o           = 1'b0;
        ram_en_o        = 1'b0;
        ram_we_o        = 1'b0;
        ram_we_tag_o    = 1'b0;
        ram_wdata_tag_o = 1'b0;
        ram_addr_o      = '0;
        ram_wdata_o     = '0;
        ram_be_o        = '0;
        if (w_sweep_active) begin
            ram_en_o     = 1'b1;
            ram_we_tag_o = 1'b1;
            ram_be_o     = '1;
            ram_addr_o   = w_sweep_addr;
        end else begin
            gnt_o = 1'b1;
            if (req_i && w_aligned) begin
                ram_en_o        = 1'b1;
                ram_addr_o      = addr_i;
                ram_we_o        = we_i;
                ram_we_tag_o    = we_i & we_tag_i;
                ram_wdata_o     = wdata_i;
                ram_wdata_tag_o = wdata_tag_i;
                ram_be_o        = be_i;
            end
        end
    end

    logic resp_valid_q, resp_valid_d;
    logic resp_read_q,  resp_read_d;
    logic resp_err_q,   resp_err_d;

    // Response bookkeeping captured on every accepted request.
    always_comb begin
        resp_valid_d = req_i & gnt_o;
        resp_read_d  = req_i & gnt_o & ~we_i & w_aligned;
        resp_err_d   = req_i & gnt_o & ~w_aligned;
    end

    // Response register; reset drops any response still in flight.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_read_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_read_q  <= resp_read_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM read data is only exposed for aligned reads; all else returns zero.
    assign rvalid_o    = resp_valid_q;
    assign err_o       = resp_err_q;
    assign rdata_o     = resp_read_q ? ram_rdata_i     : '0;
    assign rdata_tag_o = resp_read_q ? ram_rdata_tag_i : '0;

endmodule
`default_nettype wire
